// File: rtl/gate_tester_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gate_tester_pkg
//  Purpose  : Shared types, constants and the gate truth-table helper used by
//             the 74xx 2-input gate chip tester.
//  Contents : gate_type_e   - selectable gate function (NAND/NOR/AND/OR/XOR)
//             state_e       - tester FSM states
//             NUM_STEPS     - stimulus steps per test
//             FAIL_STEP_BADTYPE - Fail_Step code for an unsupported gate type
//             gate_expected - expected output of one gate for inputs a, b
//  Revision : 1.0 - initial release
// ============================================================================
package gate_tester_pkg;

    typedef enum logic [2:0] {
        GATE_NAND = 3'd0,
        GATE_NOR  = 3'd1,
        GATE_AND  = 3'd2,
        GATE_OR   = 3'd3,
        GATE_XOR  = 3'd4
    } gate_type_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int         NUM_STEPS         = 8;
    localparam logic [2:0] FAIL_STEP_BADTYPE = 3'b111;

    function automatic logic gate_expected(input gate_type_e gtype,
                                           input logic       a,
                                           input logic       b);
        logic y;
        case (gtype)
            GATE_NAND: y = ~(a & b);
            GATE_NOR:  y = ~(a | b);
            GATE_AND:  y = a & b;
            GATE_OR:   y = a | b;
            GATE_XOR:  y = a ^ b;
            default:   y = 1'b0;
        endcase
        return y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : Two-flop synchroniser for asynchronous inputs, any width.
//  Ports    : Clk   in  1      system clock
//             Reset in  1      synchronous, active-high; clears both stages
//             D     in  WIDTH  asynchronous input
//             Q     out WIDTH  synchronised output (2-cycle latency)
//  Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= D;
            r_sync <= r_meta;
        end
    end

    assign Q = r_sync;

endmodule
`default_nettype wire

// File: rtl/gate_chip_tester.sv
`default_nettype none
// ============================================================================
//  Module   : gate_chip_tester
//  Purpose  : Run-time selectable tester for 74xx quad/hex 2-input gate chips.
//             Drives an 8-step stimulus (uniform truth-table sweep, then a
//             per-gate skewed sweep that exposes inter-gate shorts), samples
//             the chip outputs through a synchroniser and reports pass/fail
//             with the first failing gate and step.
//  Ports    : Clk, Reset          clock, synchronous active-high reset
//             Run                 start request (honoured in IDLE/DONE only)
//             Gate_Type [2:0]     gate function, latched on accepted Run
//             Sense_Y  [N-1:0]    chip gate outputs (asynchronous)
//             Drive_A/Drive_B     per-gate A/B inputs
//             Drive_En            pin drivers enabled
//             Busy, Done, RSLT    status; RSLT=1 means pass, valid with Done
//             Fail_Gate, Fail_Step  lowest failing gate and its step
//  Revision : 1.0 - initial release
// ============================================================================
module gate_chip_tester
    import gate_tester_pkg::*;
#(
    parameter int NUM_GATES     = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Run,
    input  logic [2:0]                   Gate_Type,
    input  logic [NUM_GATES-1:0]         Sense_Y,
    output logic [NUM_GATES-1:0]         Drive_A,
    output logic [NUM_GATES-1:0]         Drive_B,
    output logic                         Drive_En,
    output logic                         Busy,
    output logic                         Done,
    output logic                         RSLT,
    output logic [$clog2(NUM_GATES)-1:0] Fail_Gate,
    output logic [2:0]                   Fail_Step
);

    localparam int c_gate_w = $clog2(NUM_GATES);
    // Settle load covers the chip settle time plus the 2-flop synchroniser.
    localparam int c_cnt_w  = $clog2(SETTLE_CYCLES + 3);
    localparam logic [c_cnt_w-1:0] c_settle_load = c_cnt_w'(SETTLE_CYCLES + 2);
    localparam logic [2:0]         c_last_step   = 3'(NUM_STEPS - 1);

    state_e               r_state,     w_next_state;
    logic [2:0]           r_step,      w_next_step;
    logic [c_cnt_w-1:0]   r_settle,    w_next_settle;
    gate_type_e           r_gate_type, w_next_gate_type;

    logic                 w_next_rslt;
    logic [c_gate_w-1:0]  w_next_fail_gate;
    logic [2:0]           w_next_fail_step;
    logic                 w_next_en;
    logic [NUM_GATES-1:0] w_next_a;
    logic [NUM_GATES-1:0] w_next_b;

    logic [NUM_GATES-1:0] w_sense;
    logic [NUM_GATES-1:0] w_miss;
    logic [c_gate_w-1:0]  w_first_miss;

    sync_2ff #(
        .WIDTH (NUM_GATES)
    ) u_sense_sync (
        .Clk   (Clk),
        .Reset (Reset),
        .D     (Sense_Y),
        .Q     (w_sense)
    );

    // Per-gate stimulus for the step about to be presented, and mismatch
    // detection against the vector currently held on the pins.
    for (genvar gi = 0; gi < NUM_GATES; gi++) begin : g_gate
        logic [1:0] w_vec;
        // Steps 4..7 rotate the vector by gate index so neighbouring gates
        // see different inputs and a short between outputs becomes visible.
        assign w_vec       = w_next_step[2] ? (w_next_step[1:0] + 2'(gi))
                                            : w_next_step[1:0];
        assign w_next_a[gi] = w_next_en & w_vec[1];
        assign w_next_b[gi] = w_next_en & w_vec[0];
        assign w_miss[gi]   = w_sense[gi] !=
                              gate_expected(r_gate_type, Drive_A[gi], Drive_B[gi]);
    end

    // Scan downward so the lowest mismatching index is the one kept.
    always_comb begin
        w_first_miss = '0;
        for (int i = NUM_GATES - 1; i >= 0; i--) begin
            if (w_miss[i]) begin
                w_first_miss = c_gate_w'(i);
            end
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_step      = r_step;
        w_next_settle    = r_settle;
        w_next_gate_type = r_gate_type;
        w_next_rslt      = RSLT;
        w_next_fail_gate = Fail_Gate;
        w_next_fail_step = Fail_Step;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (Run) begin
                    w_next_rslt      = 1'b0;
                    w_next_fail_gate = '0;
                    w_next_fail_step = '0;
                    w_next_step      = '0;
                    if (Gate_Type > GATE_XOR) begin
                        w_next_state     = ST_DONE;
                        w_next_fail_step = FAIL_STEP_BADTYPE;
                    end else begin
                        w_next_gate_type = gate_type_e'(Gate_Type);
                        w_next_settle    = c_settle_load;
                        w_next_state     = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: begin
                if (r_settle == c_cnt_w'(1)) begin
                    w_next_state = ST_SAMPLE;
                end else begin
                    w_next_settle = r_settle - c_cnt_w'(1);
                end
            end
            ST_SAMPLE: begin
                if (|w_miss) begin
                    w_next_state     = ST_DONE;
                    w_next_rslt      = 1'b0;
                    w_next_fail_gate = w_first_miss;
                    w_next_fail_step = r_step;
                end else if (r_step == c_last_step) begin
                    w_next_state = ST_DONE;
                    w_next_rslt  = 1'b1;
                end else begin
                    w_next_step   = r_step + 3'd1;
                    w_next_settle = c_settle_load;
                    w_next_state  = ST_DRIVE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        w_next_en = (w_next_state == ST_DRIVE) || (w_next_state == ST_SAMPLE);
    end

    // Outputs are registered from the next-state values so they line up with
    // the state they describe.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_step      <= '0;
            r_settle    <= '0;
            r_gate_type <= GATE_NAND;
            Drive_A     <= '0;
            Drive_B     <= '0;
            Drive_En    <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            RSLT        <= 1'b0;
            Fail_Gate   <= '0;
            Fail_Step   <= '0;
        end else begin
            r_state     <= w_next_state;
            r_step      <= w_next_step;
            r_settle    <= w_next_settle;
            r_gate_type <= w_next_gate_type;
            Drive_A     <= w_next_a;
            Drive_B     <= w_next_b;
            Drive_En    <= w_next_en;
            Busy        <= w_next_en;
            Done        <= (w_next_state == ST_DONE);
            RSLT        <= w_next_rslt;
            Fail_Gate   <= w_next_fail_gate;
            Fail_Step   <= w_next_fail_step;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gate_chip_tester.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gate_chip_tester
//  Purpose  : Directed self-checking bench for gate_chip_tester with a
//             behavioural 4-gate chip model and injectable faults.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gate_chip_tester;

    localparam int c_gates  = 4;
    localparam int c_settle = 4;
    localparam int c_step   = c_settle + 3;

    logic               Clk = 1'b0;
    logic               Reset;
    logic               Run;
    logic [2:0]         Gate_Type;
    logic [c_gates-1:0] Sense_Y;
    logic [c_gates-1:0] Drive_A;
    logic [c_gates-1:0] Drive_B;
    logic               Drive_En;
    logic               Busy;
    logic               Done;
    logic               RSLT;
    logic [1:0]         Fail_Gate;
    logic [2:0]         Fail_Step;

    // Chip model controls: model_type is the chip's real function, fault
    // selects 0 = healthy, 1 = gate 2 stuck-at-0, 2 = gate 1 shorted to gate 0.
    int model_type;
    int fault;

    int n_vec  = 0;
    int n_miss = 0;

    gate_chip_tester #(
        .NUM_GATES     (c_gates),
        .SETTLE_CYCLES (c_settle)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Run       (Run),
        .Gate_Type (Gate_Type),
        .Sense_Y   (Sense_Y),
        .Drive_A   (Drive_A),
        .Drive_B   (Drive_B),
        .Drive_En  (Drive_En),
        .Busy      (Busy),
        .Done      (Done),
        .RSLT      (RSLT),
        .Fail_Gate (Fail_Gate),
        .Fail_Step (Fail_Step)
    );

    always #5 Clk = ~Clk;

    always_comb begin
        logic [c_gates-1:0] y;
        y = '0;
        for (int i = 0; i < c_gates; i++) begin
            case ({Drive_A[i], Drive_B[i]})
                2'b00:   y[i] = (model_type == 0) || (model_type == 1);
                2'b11:   y[i] = (model_type == 2) || (model_type == 3);
                default: y[i] = (model_type == 0) || (model_type == 3) || (model_type == 4);
            endcase
        end
        if (fault == 1) y[2] = 1'b0;
        if (fault == 2) y[1] = y[0];
        Sense_Y = y;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        Run   = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Pulses Run in cycle 0 and follows the test to Done, checking timing,
    // status and Busy/Drive_En durations. disturb re-pulses Run with a new
    // Gate_Type in cycle 20.
    task automatic run_test(input string name, input int gtype, input int exp_done,
                            input int exp_rslt, input int exp_fg, input int exp_fs,
                            input bit disturb, input bit chk_drive);
        int cyc;
        int busy_cyc;
        int en_cyc;
        bit done_seen;
        @(negedge Clk);
        Run       = 1'b1;
        Gate_Type = 3'(gtype);
        cyc = 0; busy_cyc = 0; en_cyc = 0; done_seen = 1'b0;
        while (!done_seen && cyc < 200) begin
            @(negedge Clk);
            cyc++;
            if (cyc == 1) Run = 1'b0;
            if (disturb && cyc == 20) begin
                Run       = 1'b1;
                Gate_Type = 3'd0;
            end
            if (disturb && cyc == 21) Run = 1'b0;
            if (chk_drive && cyc == 1 + c_step) begin
                check_val({name, " step1 A"}, int'(Drive_A), 0);
                check_val({name, " step1 B"}, int'(Drive_B), 15);
            end
            if (chk_drive && cyc == 1 + 6 * c_step) begin
                check_val({name, " step6 A"}, int'(Drive_A), 3);
                check_val({name, " step6 B"}, int'(Drive_B), 10);
            end
            if (Busy) busy_cyc++;
            if (Drive_En) en_cyc++;
            if (Done) done_seen = 1'b1;
        end
        check_val({name, " done cycle"}, cyc, exp_done);
        check_val({name, " rslt"}, int'(RSLT), exp_rslt);
        check_val({name, " fail_gate"}, int'(Fail_Gate), exp_fg);
        check_val({name, " fail_step"}, int'(Fail_Step), exp_fs);
        check_val({name, " busy cycles"}, busy_cyc, exp_done - 1);
        check_val({name, " en cycles"}, en_cyc, exp_done - 1);
        @(negedge Clk);
        check_val({name, " en after done"}, int'(Drive_En), 0);
        check_val({name, " done held"}, int'(Done), 1);
    endtask

    task automatic check_reset_vals(input string name);
        check_val({name, " A"}, int'(Drive_A), 0);
        check_val({name, " B"}, int'(Drive_B), 0);
        check_val({name, " en"}, int'(Drive_En), 0);
        check_val({name, " busy"}, int'(Busy), 0);
        check_val({name, " done"}, int'(Done), 0);
        check_val({name, " rslt"}, int'(RSLT), 0);
        check_val({name, " fgate"}, int'(Fail_Gate), 0);
        check_val({name, " fstep"}, int'(Fail_Step), 0);
    endtask

    initial begin
        Reset      = 1'b1;
        Run        = 1'b0;
        Gate_Type  = 3'd0;
        model_type = 0;
        fault      = 0;
        repeat (3) @(negedge Clk);
        check_reset_vals("reset");
        Reset = 1'b0;

        // Healthy NAND: full pass, Done in cycle 57.
        run_test("nand_ok", 0, 1 + 8 * c_step, 1, 0, 0, 1'b0, 1'b1);

        // NOR with gate 2 stuck-at-0 fails at step 0.
        do_reset();
        model_type = 1; fault = 1;
        run_test("nor_stuck", 1, 1 + c_step, 0, 2, 0, 1'b0, 1'b0);

        // NAND with gate 1 shorted to gate 0 survives until the skewed step 6.
        do_reset();
        model_type = 0; fault = 2;
        run_test("nand_short", 0, 1 + 7 * c_step, 0, 1, 6, 1'b0, 1'b0);

        // Unsupported gate type finishes immediately, pins never driven.
        do_reset();
        fault = 0;
        run_test("bad_type", 6, 1, 0, 0, 7, 1'b0, 1'b0);

        // XOR with an ignored Run/Gate_Type change mid-run, then restart.
        do_reset();
        model_type = 4;
        run_test("xor_dist", 4, 1 + 8 * c_step, 1, 0, 0, 1'b1, 1'b0);
        Run       = 1'b1;
        Gate_Type = 3'd4;
        @(negedge Clk);
        Run = 1'b0;
        check_val("restart done cleared", int'(Done), 0);
        check_val("restart busy", int'(Busy), 1);

        // Reset in cycle 30 of a run abandons it; a following run is clean.
        do_reset();
        model_type = 0;
        @(negedge Clk);
        Run       = 1'b1;
        Gate_Type = 3'd0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge Clk);
            if (c == 1) Run = 1'b0;
        end
        check_val("midrun busy", int'(Busy), 1);
        Reset = 1'b1;
        @(negedge Clk);
        check_reset_vals("midrun reset");
        Reset = 1'b0;
        run_test("after_reset", 0, 1 + 8 * c_step, 1, 0, 0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
